lif_aer_encoder: RTL



---
 rtl/lif_pkg.sv | 25 ++
 rtl/lif_aer_fifo.sv | 60 ++++++
 rtl/lif_aer_encoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants and event type for the LIF AER encoder slice.
package lif_pkg;

    localparam int N_NEURONS = 8;
    localparam int TS_W      = 8;
    localparam int AW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int PCW       = $clog2(N_NEURONS + 1);

    // One address-event word: which neuron fired and when it was serialised.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [TS_W-1:0] ts;
    } aer_event_t;

    // Number of set bits in a spike-sized vector.
    function automatic logic [PCW-1:0] popcount(input logic [N_NEURONS-1:0] v);
        logic [PCW-1:0] sum;
        sum = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            sum = sum + PCW'(v[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/lif_aer_fifo.sv
// First-word fall-through FIFO of AER events. The head entry is visible on
// pop_data whenever empty is low. A push while full is accepted only if a pop
// happens in the same cycle, so occupancy stays at DEPTH.
module lif_aer_fifo
    import lif_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  aer_event_t        push_data,
    input  logic              pop,
    output aer_event_t        pop_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    aer_event_t        mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr_reg];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy update; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lif_aer_encoder.sv
// LIF spike vector to address-event serialiser.
// Samples spike_in every enabled cycle into a pending vector, grants the
// lowest pending neuron into a FWFT FIFO as {index, timestamp}, and counts
// spikes that arrive while their neuron is still pending.
// Build option: define LIF_AER_EDGE_EN to sample rising edges of spike_in
// instead of levels (a held-high line then yields a single event).
module lif_aer_encoder
    import lif_pkg::*;
#(
    parameter int  FIFO_DEPTH = 8,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [AW-1:0]        aer_addr,
    output logic [TS_W-1:0]      aer_ts,
    output logic [CW-1:0]        fifo_count,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    logic [TS_W-1:0]      ts_reg;
    logic [N_NEURONS-1:0] pend_reg;
    logic [N_NEURONS-1:0] pend_next;
    logic [N_NEURONS-1:0] sample;
    logic [N_NEURONS-1:0] grant_vec;
    logic [N_NEURONS:0]   lower_any;
    logic [N_NEURONS-1:0] drop_vec;
    logic [AW-1:0]        grant_idx;
    logic                 grant_any;
    logic                 can_grant;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           drop_count_reg;
    logic [7:0]           drop_count_next;
    logic [8:0]           drop_sum;
    logic                 overflow_reg;
    aer_event_t           push_event;
    aer_event_t           head_event;

`ifdef LIF_AER_EDGE_EN
    logic [N_NEURONS-1:0] spike_q_reg;

    // Previous spike levels, advanced only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q_reg <= '0;
        end else if (ena) begin
            spike_q_reg <= spike_in;
        end
    end

    assign sample = spike_in & ~spike_q_reg;
`else
    assign sample = spike_in;
`endif

    assign pop       = aer_valid & aer_ready;
    assign can_grant = ena & (|pend_reg) & (~fifo_full | pop);

    // Lowest-index priority: a bit wins when no lower bit is pending.
    assign lower_any[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_prio
            assign lower_any[gi+1] = lower_any[gi] | pend_reg[gi];
            assign grant_vec[gi]   = can_grant & pend_reg[gi] & ~lower_any[gi];
        end
    endgenerate

    assign grant_any = |grant_vec;

    // One-hot grant to binary index; OR-ing is safe because at most one bit is set.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (grant_vec[i]) grant_idx = grant_idx | AW'(i);
        end
    end

    // Pending update and drop detection: a re-sampled bit that was granted this
    // cycle is a fresh spike, one that is still waiting is lost.
    always_comb begin
        pend_next = pend_reg;
        drop_vec  = '0;
        if (ena) begin
            pend_next = (pend_reg & ~grant_vec) | sample;
            drop_vec  = sample & pend_reg & ~grant_vec;
        end
    end

    assign drop_sum        = {1'b0, drop_count_reg} + 9'(popcount(drop_vec));
    assign drop_count_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    // Timestamp, pending vector and drop statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg         <= '0;
            pend_reg       <= '0;
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            pend_reg       <= pend_next;
            drop_count_reg <= drop_count_next;
            if (ena)       ts_reg       <= ts_reg + TS_W'(1);
            if (|drop_vec) overflow_reg <= 1'b1;
        end
    end

    assign push_event.addr = grant_idx;
    assign push_event.ts   = ts_reg;

    lif_aer_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant_any),
        .push_data (push_event),
        .pop       (pop),
        .pop_data  (head_event),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head data is masked while empty so stale storage never reaches the pins.
    assign aer_valid  = ~fifo_empty;
    assign aer_addr   = aer_valid ? head_event.addr : '0;
    assign aer_ts     = aer_valid ? head_event.ts   : '0;
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

endmodule
